// File: rtl/tt_um_njzhu_calc_tester.sv
// rtl/tt_um_njzhu_calc_tester.sv - exhaustive sweep tester for an external 4-bit calculator
module tt_um_njzhu_calc_tester #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [9:0] IDX_LAST  = 10'd1023;

  logic       sync1_q, sync2_q, prev_q, fill1_q, fill2_q;
  logic       start_edge;
  state_t     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] err_q, err_d;
  logic       fail_q, fail_d;
  logic       busy_q, busy_d;
  logic [7:0] uo_q, uo_d;
  logic [1:0] op_q, op_d;
  logic       mismatch;
  logic [7:0] err_inc;
  logic [9:0] idx_nx;
  logic       unused_ok;

  // Reference result for one vector: a=v[3:0], b=v[7:4], op=v[9:8], all modulo 16
  function automatic logic [3:0] golden(input logic [9:0] v);
    logic [3:0] a;
    logic [3:0] b;
    a = v[3:0];
    b = v[7:4];
    unique case (v[9:8])
      2'b00:   golden = a + b;
      2'b01:   golden = a - b;
      2'b10:   golden = a | b;
      default: golden = (a == b) ? 4'd0 : 4'd1;
    endcase
  endfunction

  // Two-flop start synchronizer; the edge detector stays disarmed (prev=1) until the
  // synchronizer holds real input, so a start already high at reset release is no edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill1_q <= 1'b0;
      fill2_q <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ui_in[0];
      sync2_q <= sync1_q;
      fill1_q <= 1'b1;
      fill2_q <= fill1_q;
      prev_q  <= fill2_q ? sync2_q : 1'b1;
    end
  end

  assign start_edge = fill2_q & sync2_q & ~prev_q;
  assign mismatch   = (uio_in[5:2] != golden(idx_q));
  assign err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign idx_nx     = idx_q + 10'd1;

  // Next-state and next-output computation for the sweep FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    uo_d    = uo_q;
    op_d    = op_q;
    unique case (state_q)
      ST_RUN: begin
        if (wait_q == WAIT_LAST) begin
          wait_d = 4'd0;
          if (mismatch) begin
            err_d  = err_inc;
            fail_d = 1'b1;
          end
          if (mismatch && ui_in[1]) begin
            // hold the failing vector on the pins for inspection
            state_d = ST_HALT;
            busy_d  = 1'b0;
          end else if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            uo_d    = mismatch ? err_inc : err_q;
            op_d    = 2'b00;
          end else begin
            idx_d = idx_nx;
            uo_d  = idx_nx[7:0];
            op_d  = idx_nx[9:8];
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: begin
        // IDLE, HALT and DONE all restart the sweep from vector 0 on a start edge
        if (start_edge) begin
          state_d = ST_RUN;
          idx_d   = 10'd0;
          wait_d  = 4'd0;
          err_d   = 8'd0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          uo_d    = 8'd0;
          op_d    = 2'b00;
        end
      end
    endcase
  end

  // Sweep FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 10'd0;
      wait_q  <= 4'd0;
      err_q   <= 8'd0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      uo_q    <= 8'd0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      uo_q    <= uo_d;
      op_q    <= op_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {fail_q, busy_q, 4'b0000, op_q};
  assign uio_oe  = 8'b1100_0011;

  assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in[7:6], uio_in[1:0]};

endmodule

// File: doc/tt_um_njzhu_calc_tester.md
TT_UM_NJZHU_CALC_TESTER -- requirements
Module: tt_um_njzhu_calc_tester

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, range 1..15: clock edges from driving a vector to sampling its result.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  ignored.
REQ-005 ui_in  input  8  [0]=start (level, async to design); [1]=halt_on_error; [7:2] unused.
REQ-006 uo_out  output  8  while running/halted: [3:0]=operand a, [7:4]=operand b (wired to the calculator's switch inputs); in DONE: error count.
REQ-007 uio_in  input  8  [5:2]=4-bit calculator result; all other bits ignored.
REQ-008 uio_out  output  8  [1:0]=op; [5:2]=0; [6]=busy; [7]=fail.
REQ-009 uio_oe  output  8  SHALL be constant 8'b1100_0011 at all times, including reset.

Function
REQ-010 10-bit vector index idx maps as a=idx[3:0], b=idx[7:4], op=idx[9:8]; a sweep covers idx 0..1023 ascending.
REQ-011 Golden model, 4-bit modulo-16: op 00 a+b; 01 a-b; 10 a|b; 11 4'd0 if a==b else 4'd1.
REQ-012 start is passed through a 2-flop synchronizer and rising-edge detected; only a synchronized 0->1 transition counts; a held-high start never retriggers.
REQ-013 FSM states: IDLE, RUN, HALT, DONE.
REQ-014 IDLE: uo_out=0, op=0, busy=0; start edge -> RUN with idx=0, error count=0, fail=0.
REQ-015 start rising at ui_in[0] before edge n: vector 0 SHALL be on uo_out/uio_out[1:0] after edge n+2.
REQ-016 RUN: busy=1; a/b/op outputs are registered and reflect current idx; a wait counter counts WAIT_CYCLES edges per vector.
REQ-017 On the WAIT_CYCLES-th edge after a vector is driven, uio_in[5:2] SHALL be compared with the model for that vector; on the same edge idx increments and the next vector is driven (no idle cycle); one vector per WAIT_CYCLES cycles.
REQ-018 Mismatch: fail set (sticky until next start); error count +1, saturating at 8'hFF.
REQ-019 Mismatch with halt_on_error=1 (sampled on the compare edge): go to HALT, idx not incremented, outputs hold the failing vector, busy=0, fail=1.
REQ-020 Compare of idx 1023 with no halt: go to DONE; uo_out=error count, op=0, busy=0, fail held.
REQ-021 HALT or DONE + start edge: restart sweep exactly as REQ-014/015 (count and fail cleared).
REQ-022 start edges during RUN SHALL be ignored; halt_on_error changes mid-sweep take effect at the next compare.
REQ-023 idx SHALL never wrap past 1023 within a sweep.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, idx=0, wait counter=0, error count=0, fail=0, busy=0, uo_out=0, uio_out=0, synchronizer flops=0.
REQ-025 Reset asserted mid-sweep aborts it; after release, the block waits in IDLE for a new start edge (a start already high at release is not an edge).

Verification
REQ-026 Reset: rst_n low with random ui_in/uio_in -> uo_out=0, uio_out=0, uio_oe=8'hC3 without a clock edge.
REQ-027 Loopback to a correct registered calculator model, WAIT_CYCLES=2, halt=0 -> DONE after 2048 RUN cycles, fail=0, uo_out=8'h00; every idx driven once, in order.
REQ-028 Model result bit 3 stuck at 0, halt=0 -> DONE, fail=1, uo_out=8'hFF (saturated).
REQ-029 Model op 11 inverted, halt=1 -> HALT with uo_out=8'h00, uio_out[1:0]=2'b11, uio_out[7:6]=2'b10; new start edge -> sweep restarts at idx 0 with fail=0.
REQ-030 rst_n pulsed low at idx~300 with start held high -> IDLE, no restart until start falls and rises again; then vector 0 appears 3 edges after the rise.
REQ-031 WAIT_CYCLES=1 and 15 with correct model -> fail=0, sweep length 1024 and 15360 cycles respectively.
